// File: rtl/float_copro_arbiter.sv
// Two-requester arbiter that shares one float coprocessor using four-phase handshakes.
// Define FLOAT_ARB_ROUND_ROBIN_EN for round-robin on simultaneous requests; default is fixed req0 priority.
module float_copro_arbiter #(
    parameter int OPCODE_W = 11,
    parameter int DATA_W   = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req0_valid,
    input  logic [OPCODE_W-1:0] req0_opcode,
    input  logic [DATA_W-1:0]   req0_op0,
    input  logic [DATA_W-1:0]   req0_op1,
    output logic                req0_complete,
    output logic [DATA_W-1:0]   req0_result,
    input  logic                req1_valid,
    input  logic [OPCODE_W-1:0] req1_opcode,
    input  logic [DATA_W-1:0]   req1_op0,
    input  logic [DATA_W-1:0]   req1_op1,
    output logic                req1_complete,
    output logic [DATA_W-1:0]   req1_result,
    output logic                copro_valid,
    output logic [OPCODE_W-1:0] copro_opcode,
    output logic [DATA_W-1:0]   copro_op0,
    output logic [DATA_W-1:0]   copro_op1,
    input  logic                copro_complete,
    input  logic [DATA_W-1:0]   copro_result,
    output logic                grant_id,
    output logic                busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, RELEASE, RESPOND} state_t;

    typedef struct packed {
        logic [OPCODE_W-1:0] opcode;
        logic [DATA_W-1:0]   op0;
        logic [DATA_W-1:0]   op1;
    } req_t;

    state_t            state;
    logic              last_grant;
    logic [DATA_W-1:0] result_q;
    logic              any_req;
    logic              winner;
    logic              owner_valid;
    req_t              req0_pkt;
    req_t              req1_pkt;
    req_t              win_pkt;

    assign req0_pkt    = '{opcode: req0_opcode, op0: req0_op0, op1: req0_op1};
    assign req1_pkt    = '{opcode: req1_opcode, op0: req1_op0, op1: req1_op1};
    assign any_req     = req0_valid | req1_valid;
    assign owner_valid = grant_id ? req1_valid : req0_valid;

`ifdef FLOAT_ARB_ROUND_ROBIN_EN
    // On a tie the requester that did not win last time goes next.
    assign winner = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
`else
    assign winner = ~req0_valid;
`endif

    assign win_pkt = winner ? req1_pkt : req0_pkt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            copro_valid   <= 1'b0;
            copro_opcode  <= '0;
            copro_op0     <= '0;
            copro_op1     <= '0;
            req0_complete <= 1'b0;
            req1_complete <= 1'b0;
            req0_result   <= '0;
            req1_result   <= '0;
            result_q      <= '0;
            grant_id      <= 1'b0;
            busy          <= 1'b0;
            last_grant    <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    // A complete still high here belongs to an abandoned transaction.
                    if (any_req && !copro_complete) begin
                        grant_id     <= winner;
                        last_grant   <= winner;
                        copro_opcode <= win_pkt.opcode;
                        copro_op0    <= win_pkt.op0;
                        copro_op1    <= win_pkt.op1;
                        copro_valid  <= 1'b1;
                        busy         <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (copro_complete) begin
                        result_q    <= copro_result;
                        copro_valid <= 1'b0;
                        state       <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!copro_complete) begin
                        if (grant_id) begin
                            req1_result   <= result_q;
                            req1_complete <= 1'b1;
                        end else begin
                            req0_result   <= result_q;
                            req0_complete <= 1'b1;
                        end
                        state <= RESPOND;
                    end
                end
                RESPOND: begin
                    // An owner that already dropped valid sees a single-cycle complete.
                    if (!owner_valid) begin
                        req0_complete <= 1'b0;
                        req1_complete <= 1'b0;
                        busy          <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
